// File: rtl/jtag_vector_player.sv
// JTAG vector playback stage with a parametrised vector RAM width. It streams
// {tms,tdi} steps over a ready/next handshake and repeats a step window N
// times, firing one delayed ADC trigger per pass. Returned TDO bits are packed
// LSB-first into 32-bit capture RAM words.
module jtag_vector_player #(
  parameter int unsigned J_D_WIDTH   = 8,
  parameter int unsigned J_A_WIDTH   = 12,
  parameter int unsigned CAP_A_WIDTH = 10
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [31:0]            vector_start,
  input  logic [31:0]            vector_end,
  input  logic [31:0]            vector_number_repeat,
  input  logic [31:0]            adc_start_delay,
  output logic [J_A_WIDTH-1:0]   vec_addr,
  input  logic [J_D_WIDTH-1:0]   vec_rd_data,
  output logic [1:0]             vector_data,
  output logic                   data_ready,
  input  logic                   get_next_data,
  output logic                   wait_state,
  input  logic                   tdo,
  input  logic                   tdo_valid,
  output logic                   cap_we,
  output logic [CAP_A_WIDTH-1:0] cap_addr,
  output logic [31:0]            cap_wr_data,
  output logic                   adc_start,
  output logic                   adc_sequence_one,
  output logic                   busy,
  output logic                   done,
  output logic                   error
);

  localparam int unsigned K = J_D_WIDTH / 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAITRD,
    S_PRESENT,
    S_PASS_END,
    S_DONE
  } state_t;

  state_t r_state, w_next;

  logic [31:0]            r_vstart, r_vend, r_npass, r_delay;
  logic [31:0]            r_step, r_lane, r_start_lane, r_pass;
  logic [J_A_WIDTH-1:0]   r_waddr, r_start_waddr;
  logic [J_D_WIDTH-1:0]   r_word;
  logic                   r_seq, r_error, r_first;
  logic                   r_adc_armed;
  logic [31:0]            r_adc_cnt;
  logic [31:0]            r_cap_sr, r_cap_data;
  logic [4:0]             r_cap_cnt;
  logic [CAP_A_WIDTH-1:0] r_cap_ptr, r_cap_addr;
  logic                   r_cap_we;

  logic                   w_active, w_abort, w_consume, w_last, w_lane_last;
  logic                   w_more, w_cfg_bad, w_start_idle;
  logic [J_A_WIDTH-1:0]   w_start_waddr;
  logic [31:0]            w_start_lane;
  logic [1:0]             w_lane_bits;
  logic                   w_first, w_adc_fire;
  logic [31:0]            w_adc_cnt;
  logic                   w_cap_en, w_cap_wr;
  logic [31:0]            w_cap_word;

  assign w_active      = (r_state == S_FETCH) || (r_state == S_WAITRD) ||
                         (r_state == S_PRESENT) || (r_state == S_PASS_END);
  assign w_abort       = abort && w_active;
  assign w_consume     = (r_state == S_PRESENT) && get_next_data && !abort;
  assign w_last        = (r_step == r_vend);
  assign w_lane_last   = (r_lane == K - 1);
  assign w_more        = (r_pass + 32'd1) < r_npass;
  assign w_cfg_bad     = (vector_end < vector_start);
  assign w_start_idle  = (r_state == S_IDLE) && start;
  assign w_start_waddr = J_A_WIDTH'(vector_start / K);
  assign w_start_lane  = vector_start % K;
  assign w_lane_bits   = 2'(r_word >> {r_lane, 1'b0});

  // Delay counter is forced to 0 on the first present of a pass so that a
  // delay of 0 fires in that same cycle.
  assign w_first    = (r_state == S_PRESENT) && r_first;
  assign w_adc_cnt  = w_first ? 32'd0 : r_adc_cnt;
  assign w_adc_fire = (w_first || r_adc_armed) && (w_adc_cnt == r_delay);

  // DONE flushes any pending bits, including a tdo bit arriving that cycle.
  assign w_cap_en   = (r_state != S_IDLE) && !w_abort;
  assign w_cap_word = r_cap_sr | ((tdo_valid && tdo) ? (32'd1 << r_cap_cnt) : 32'd0);
  assign w_cap_wr   = w_cap_en &&
                      ((tdo_valid && (r_cap_cnt == 5'd31)) ||
                       ((r_state == S_DONE) && (tdo_valid || (r_cap_cnt != 5'd0))));

  assign vec_addr         = r_waddr;
  assign adc_start        = w_adc_fire;
  assign adc_sequence_one = r_seq;
  assign error            = r_error;
  assign cap_we           = r_cap_we;
  assign cap_addr         = r_cap_addr;
  assign cap_wr_data      = r_cap_data;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state decode and handshake/status outputs.
  always_comb begin
    w_next      = r_state;
    data_ready  = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = w_cfg_bad ? S_DONE : S_FETCH;
      end
      S_FETCH: begin
        busy   = 1'b1;
        w_next = S_WAITRD;
      end
      S_WAITRD: begin
        busy   = 1'b1;
        w_next = S_PRESENT;
      end
      S_PRESENT: begin
        busy       = 1'b1;
        data_ready = 1'b1;
        if (w_consume) begin
          if (w_last)           w_next = w_more ? S_PASS_END : S_DONE;
          else if (w_lane_last) w_next = S_FETCH;
        end
      end
      S_PASS_END: begin
        busy   = 1'b1;
        w_next = S_FETCH;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (w_abort) w_next = S_IDLE;
    wait_state  = busy && !data_ready;
    vector_data = data_ready ? w_lane_bits : 2'b00;
  end

  // Run configuration, step/lane walk and pass bookkeeping.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_vstart      <= '0;
      r_vend        <= '0;
      r_npass       <= '0;
      r_delay       <= '0;
      r_step        <= '0;
      r_lane        <= '0;
      r_start_lane  <= '0;
      r_pass        <= '0;
      r_waddr       <= '0;
      r_start_waddr <= '0;
      r_word        <= '0;
      r_seq         <= 1'b0;
      r_error       <= 1'b0;
      r_first       <= 1'b0;
    end else begin
      if (w_start_idle) begin
        r_error <= w_cfg_bad;
        if (!w_cfg_bad) begin
          r_vstart      <= vector_start;
          r_vend        <= vector_end;
          r_npass       <= (vector_number_repeat == 32'd0) ? 32'd1 : vector_number_repeat;
          r_delay       <= adc_start_delay;
          r_step        <= vector_start;
          r_waddr       <= w_start_waddr;
          r_lane        <= w_start_lane;
          r_start_waddr <= w_start_waddr;
          r_start_lane  <= w_start_lane;
          r_pass        <= '0;
          r_seq         <= 1'b1;
          r_first       <= 1'b1;
        end
      end
      if (r_state == S_WAITRD) r_word <= vec_rd_data;
      if (w_consume && !w_last) begin
        r_step <= r_step + 32'd1;
        if (w_lane_last) begin
          r_lane  <= '0;
          r_waddr <= r_waddr + J_A_WIDTH'(1);
        end else begin
          r_lane  <= r_lane + 32'd1;
        end
      end
      if (r_state == S_PASS_END) begin
        r_pass  <= r_pass + 32'd1;
        r_seq   <= ~r_seq;
        r_step  <= r_vstart;
        r_waddr <= r_start_waddr;
        r_lane  <= r_start_lane;
        r_first <= 1'b1;
      end
      if (w_first) r_first <= 1'b0;
      if (w_abort || (r_state == S_DONE)) begin
        r_seq   <= 1'b0;
        r_first <= 1'b0;
      end
    end
  end

  // ADC trigger delay: at most one pulse per pass, dropped at pass end.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_adc_armed <= 1'b0;
      r_adc_cnt   <= '0;
    end else begin
      r_adc_cnt <= w_adc_cnt + 32'd1;
      if (w_adc_fire)   r_adc_armed <= 1'b0;
      else if (w_first) r_adc_armed <= 1'b1;
      if (w_abort || (w_consume && w_last) || (r_state == S_IDLE)) r_adc_armed <= 1'b0;
    end
  end

  // TDO packing into 32-bit capture words.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cap_sr   <= '0;
      r_cap_cnt  <= '0;
      r_cap_ptr  <= '0;
      r_cap_addr <= '0;
      r_cap_data <= '0;
      r_cap_we   <= 1'b0;
    end else begin
      r_cap_we <= 1'b0;
      if (w_start_idle) begin
        r_cap_ptr <= '0;
        r_cap_sr  <= '0;
        r_cap_cnt <= '0;
      end else if (w_abort) begin
        r_cap_sr  <= '0;
        r_cap_cnt <= '0;
      end else if (w_cap_wr) begin
        r_cap_we   <= 1'b1;
        r_cap_addr <= r_cap_ptr;
        r_cap_data <= w_cap_word;
        r_cap_ptr  <= r_cap_ptr + CAP_A_WIDTH'(1);
        r_cap_sr   <= '0;
        r_cap_cnt  <= '0;
      end else if (w_cap_en && tdo_valid) begin
        r_cap_sr  <= w_cap_word;
        r_cap_cnt <= r_cap_cnt + 5'd1;
      end
    end
  end

endmodule

// File: doc/jtag_vector_player.md
Name: jtag_vector_player

Overview:
- Parametrised successor to the single-width JTAG vector playback stage.
- Reads packed 2-bit {tms,tdi} steps from vector RAM of configurable word width/depth and presents them to the JTAG output stage over a ready/next handshake.
- Repeats a step window N times, alternating ADC config sequence and firing a delayed ADC trigger per pass.
- New: packs returned TDO bits into 32-bit words written to a capture RAM.

Parameters:
- J_D_WIDTH, 8, vector RAM word width; even; K = J_D_WIDTH/2 steps per word.
- J_A_WIDTH, 12, vector RAM address width.
- CAP_A_WIDTH, 10, capture RAM address width (32-bit words).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle run request; ignored while busy.
- abort  in  1  terminate run.
- vector_start  in  32  first step index (step = word*K + lane).
- vector_end  in  32  last step index, inclusive.
- vector_number_repeat  in  32  pass count; 0 treated as 1.
- adc_start_delay  in  32  clk cycles from pass start to adc_start.
- vec_addr  out  J_A_WIDTH  vector RAM read address; 1-cycle read latency.
- vec_rd_data  in  J_D_WIDTH  vector RAM data.
- vector_data  out  2  {tms,tdi} of current step; lane 0 = bits[1:0].
- data_ready  out  1  vector_data valid.
- get_next_data  in  1  consumer takes current step.
- wait_state  out  1  busy & ~data_ready.
- tdo  in  1  TDO bit from output stage.
- tdo_valid  in  1  tdo strobe.
- cap_we  out  1  capture RAM write.
- cap_addr  out  CAP_A_WIDTH  capture address.
- cap_wr_data  out  32  packed TDO.
- adc_start  out  1  one-cycle ADC trigger.
- adc_sequence_one  out  1  high on odd passes (1st, 3rd...).
- busy  out  1  run active.
- done  out  1  one-cycle pulse at run end.
- error  out  1  sticky config error; cleared by next start.

Behaviour:
- Reset (reset_n=0 at clk edge): all outputs 0, FSM IDLE, capture pointer 0, pass counter 0.
- FSM: IDLE -> FETCH (drive vec_addr) -> WAITRD (1-cycle latency) -> PRESENT (data_ready=1) -> FETCH / PASS_END -> DONE -> IDLE.
- start in IDLE: if vector_end < vector_start, set error, pulse done next cycle, no data_ready. Otherwise busy=1, pass=0, step=vector_start, capture pointer 0, enter FETCH.
- Handshake: step consumed on data_ready & get_next_data. get_next_data without data_ready ignored.
- Same-word next step: zero bubble; data_ready stays 1 with the next lane on the following cycle.
- Word crossing: data_ready low for exactly 2 cycles.
- Step arithmetic: vec_addr = step / K (truncated to J_A_WIDTH, wraps at 2^J_A_WIDTH); lane = step mod K.
- Last step of pass consumed:
  - pass+1 < N: restart at vector_start; toggle adc_sequence_one.
  - otherwise: enter DONE.
- adc_sequence_one: 1 during pass 0.
- adc_start:
  - Delay counter restarts when a pass's first step is presented.
  - Pulses when count == adc_start_delay (delay 0 = same cycle as first present).
  - Pulse not fired before pass end is dropped; at most one pulse per pass.
- TDO capture (while busy):
  - Each tdo_valid shifts tdo into bit position count (LSB first).
  - On 32nd bit: cap_we=1 for one cycle with cap_addr = pointer; pointer then increments, wrapping at 2^CAP_A_WIDTH.
- DONE:
  - Flushes a partial capture word zero-padded in its upper bits; no write if 0 bits are pending.
  - tdo_valid arriving in the DONE cycle is included before the flush.
  - Then: done pulse, busy=0.
- abort: next cycle IDLE, data_ready=0, busy=0, partial capture discarded, no done pulse. abort has priority over a simultaneous consume.
- start while busy: no effect.
- reset_n mid-run: all state and outputs return to reset values; no RAM write in that cycle.

Test Plan:
- J_D_WIDTH=8, start=0, end=7, N=1, RAM words 0xE4, 0x1B, consumer always ready -> vector_data 0,1,2,3,3,2,1,0; one 2-cycle data_ready gap between steps 3 and 4; done 1 cycle after step 7; busy 0.
- start=2, end=5, N=3, adc_start_delay=1, consumer ready -> steps 2..5 three times; adc_sequence_one 1,0,1 per pass; adc_start 1 cycle after each pass's first present, 3 pulses total.
- 40 tdo_valid with tdo alternating 1,0 -> cap_we at addr 0 with 0x55555555; at run end, addr 1 with 0x00000055.
- vector_start=9, vector_end=4, start -> error=1, done pulse, data_ready never asserted.
- abort after 3 consumed steps with 5 tdo bits pending -> IDLE next cycle, no cap_we, no done; new start restarts at vector_start and capture addr 0.
- reset_n=0 mid-pass with data_ready=1 -> all outputs 0 next cycle; start after release plays normally.
